// File: rtl/fixed_round_arbiter.sv
// Round-robin arbiter that shares one fixed-point rounder between NCHAN sample streams.
// fixed_rounder: saturating round-to-nearest with a clock-enabled output pipeline.

module fixed_rounder #(
  parameter int unsigned IWIDTH   = 16,
  parameter int unsigned OWIDTH   = 10,
  parameter int unsigned PIPELINE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkena,
  input  logic              in_signed,
  input  logic [IWIDTH-1:0] in_data,
  output logic              out_signed,
  output logic [OWIDTH-1:0] out_data
);

  localparam int D = int'(IWIDTH) - int'(OWIDTH);

  logic [OWIDTH-1:0] rounded;
  logic [OWIDTH-1:0] data_q [PIPELINE];
  logic              sign_q [PIPELINE];

  generate
    if (D == 0) begin : g_pass
      assign rounded = in_data;
    end else if (D < 0) begin : g_pad
      localparam int unsigned PAD = OWIDTH - IWIDTH;
      assign rounded = {in_data, {PAD{1'b0}}};
    end else begin : g_round
      logic [OWIDTH-1:0] trunc;
      logic              half;
      logic              sticky;
      logic              at_max;
      logic              inc;

      assign trunc = in_data[IWIDTH-1:D];
      assign half  = in_data[D-1];

      if (D >= 2) begin : g_sticky
        assign sticky = |in_data[D-2:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end

      // at_max blocks the increment that would wrap past the largest code
      if (OWIDTH >= 2) begin : g_max_wide
        assign at_max = in_signed ? (&trunc[OWIDTH-2:0]) : (&trunc);
      end else begin : g_max_narrow
        assign at_max = in_signed ? 1'b1 : trunc[0];
      end

      // negatives round up only past an exact half, so halves go away from zero
      assign inc = (in_signed && trunc[OWIDTH-1]) ? (half & sticky) : (half & ~at_max);
      assign rounded = trunc + OWIDTH'(inc);
    end
  endgenerate

  // Output pipeline, frozen while clkena is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPELINE; i++) begin
        data_q[i] <= '0;
        sign_q[i] <= 1'b0;
      end
    end else if (clkena) begin
      data_q[0] <= rounded;
      sign_q[0] <= in_signed;
      for (int i = 1; i < PIPELINE; i++) begin
        data_q[i] <= data_q[i-1];
        sign_q[i] <= sign_q[i-1];
      end
    end
  end

  assign out_data   = data_q[PIPELINE-1];
  assign out_signed = sign_q[PIPELINE-1];

endmodule

module fixed_round_arbiter #(
  parameter  int unsigned NCHAN    = 4,
  parameter  int unsigned IWIDTH   = 16,
  parameter  int unsigned OWIDTH   = 10,
  parameter  int unsigned PIPELINE = 2,
  localparam int unsigned CWIDTH   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCHAN-1:0]              i_valid,
  output logic [NCHAN-1:0]              i_ready,
  input  logic [NCHAN-1:0]              i_signed,
  input  logic [NCHAN-1:0][IWIDTH-1:0]  i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [CWIDTH-1:0]             o_chan,
  output logic                          o_signed,
  output logic [OWIDTH-1:0]             o_data
);

  localparam int unsigned SWIDTH = CWIDTH + 1;

  logic              advance;
  logic              found;
  logic [CWIDTH-1:0] ptr;
  logic [CWIDTH-1:0] sel_chan;
  logic [SWIDTH-1:0] cand;
  logic [NCHAN-1:0]  grant;
  logic [IWIDTH-1:0] sel_data;
  logic              sel_signed;
  logic              rounder_reset;
  logic              sb_valid [PIPELINE];
  logic [CWIDTH-1:0] sb_chan  [PIPELINE];

  assign advance = ~o_valid | o_ready;

  // Round-robin search starting at ptr; first valid channel wins
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel_chan = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      cand = {1'b0, ptr} + SWIDTH'(i);
      if (cand >= SWIDTH'(NCHAN)) begin
        cand = cand - SWIDTH'(NCHAN);
      end
      if (!found && i_valid[cand[CWIDTH-1:0]]) begin
        found    = 1'b1;
        sel_chan = cand[CWIDTH-1:0];
      end
    end
    grant[sel_chan] = found;
  end

  assign i_ready    = grant & {NCHAN{advance}};
  assign sel_data   = found ? i_data[sel_chan] : '0;
  assign sel_signed = found & i_signed[sel_chan];

  // Pointer moves just past the channel that transferred
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found && advance) begin
      ptr <= (sel_chan == CWIDTH'(NCHAN - 1)) ? '0 : sel_chan + CWIDTH'(1);
    end
  end

  // Valid/tag sideband, aligned with the rounder pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPELINE; i++) begin
        sb_valid[i] <= 1'b0;
        sb_chan[i]  <= '0;
      end
    end else if (advance) begin
      sb_valid[0] <= found;
      sb_chan[0]  <= sel_chan;
      for (int i = 1; i < PIPELINE; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_chan[i]  <= sb_chan[i-1];
      end
    end
  end

  assign o_valid = sb_valid[PIPELINE-1];
  assign o_chan  = sb_chan[PIPELINE-1];

  assign rounder_reset = ~reset;

  fixed_rounder #(
    .IWIDTH   (IWIDTH),
    .OWIDTH   (OWIDTH),
    .PIPELINE (PIPELINE)
  ) u_rounder (
    .clk        (clk),
    .reset      (rounder_reset),
    .clkena     (advance),
    .in_signed  (sel_signed),
    .in_data    (sel_data),
    .out_signed (o_signed),
    .out_data   (o_data)
  );

endmodule

// File: tb/tb_fixed_round_arbiter.sv
// Bench for fixed_round_arbiter: per-cycle reference model plus directed literal checks.

module tb_fixed_round_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 16;
  localparam int unsigned OW = 10;
  localparam int unsigned P  = 2;
  localparam int unsigned CW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          i_valid = '0;
  logic [N-1:0]          i_ready;
  logic [N-1:0]          i_signed = '0;
  logic [N-1:0][IW-1:0]  i_data = '0;
  logic                  o_valid;
  logic                  o_ready = 1'b1;
  logic [CW-1:0]         o_chan;
  logic                  o_signed;
  logic [OW-1:0]         o_data;

  fixed_round_arbiter #(
    .NCHAN(N), .IWIDTH(IW), .OWIDTH(OW), .PIPELINE(P)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .i_signed(i_signed), .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_chan(o_chan), .o_signed(o_signed), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference rounding: nearest, ties away from zero, saturate at the top code
  function automatic logic [OW-1:0] model_round(input logic [IW-1:0] d, input logic s);
    longint scale, v, q, maxu, maxs;
    scale = longint'(1) << (IW - OW);
    maxu  = (longint'(1) << OW) - 1;
    maxs  = (longint'(1) << (OW - 1)) - 1;
    if (!s) begin
      v = longint'(d);
      q = (v + scale / 2) / scale;
      if (q > maxu) q = maxu;
    end else begin
      v = longint'($signed(d));
      if (v >= 0) begin
        q = (v + scale / 2) / scale;
        if (q > maxs) q = maxs;
      end else begin
        q = -(((-v) + scale / 2) / scale);
      end
    end
    return OW'(q);
  endfunction

  // Model state: slot P-1 is what the outputs must show
  bit            mv [P] = '{default: 1'b0};
  int            mc [P] = '{default: 0};
  bit            ms [P] = '{default: 1'b0};
  logic [OW-1:0] md [P] = '{default: '0};
  int            mptr = 0;
  bit            nv [P] = '{default: 1'b0};
  int            nc [P] = '{default: 0};
  bit            ns [P] = '{default: 1'b0};
  logic [OW-1:0] nd [P] = '{default: '0};
  int            nptr = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < P; i++) begin
        mv[i] <= 1'b0; mc[i] <= 0; ms[i] <= 1'b0; md[i] <= '0;
      end
      mptr <= 0;
    end else begin
      mv <= nv; mc <= nc; ms <= ns; md <= nd; mptr <= nptr;
    end
  end

  // Compare process: check every cycle, then compute the model's next state
  always @(negedge clk) begin
    int g;
    int k;
    bit adv;
    logic [N-1:0] er;
    adv = !mv[P-1] || o_ready;
    g = -1;
    for (int i = 0; i < N; i++) begin
      k = (mptr + i) % N;
      if (g < 0 && i_valid[CW'(k)]) g = k;
    end
    er = '0;
    if (g >= 0 && adv) er[CW'(g)] = 1'b1;
    chk("i_ready",  32'(i_ready),  32'(er));
    chk("o_valid",  32'(o_valid),  32'(mv[P-1]));
    chk("o_chan",   32'(o_chan),   32'(mc[P-1]));
    chk("o_signed", 32'(o_signed), 32'(ms[P-1]));
    chk("o_data",   32'(o_data),   32'(md[P-1]));
    nv = mv; nc = mc; ns = ms; nd = md;
    if (adv) begin
      for (int i = P - 1; i > 0; i--) begin
        nv[i] = mv[i-1]; nc[i] = mc[i-1]; ns[i] = ms[i-1]; nd[i] = md[i-1];
      end
      nv[0] = (g >= 0);
      nc[0] = (g >= 0) ? g : 0;
      ns[0] = (g >= 0) ? i_signed[CW'(g)] : 1'b0;
      nd[0] = (g >= 0) ? model_round(i_data[CW'(g)], i_signed[CW'(g)]) : '0;
    end
    nptr = (g >= 0 && adv) ? (g + 1) % N : mptr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-channel sample; result must be visible after the second edge
  task automatic round_lit(input string nm, input int ch, input logic [IW-1:0] d,
                           input logic s, input logic [OW-1:0] exp);
    i_data[CW'(ch)]   = d;
    i_signed[CW'(ch)] = s;
    i_valid = '0;
    i_valid[CW'(ch)] = 1'b1;
    @(posedge clk);
    #1 i_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk(nm, 32'(o_data), 32'(exp));
    chk({nm, "_valid"}, 32'(o_valid), 32'd1);
    chk({nm, "_chan"}, 32'(o_chan), 32'(ch));
    step();
  endtask

  logic [N-1:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data",  32'(o_data),  32'd0);
    chk("rst_o_chan",  32'(o_chan),  32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Round-robin with every channel requesting
    for (int c = 0; c < N; c++) i_data[CW'(c)] = 16'(16'h0100 * (c + 1) + 16'h0020);
    i_valid = 4'hF;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_ready", 32'(i_ready), 32'(rr_exp[j]));
      if (j >= 2) begin
        chk("rr_chan", 32'(o_chan), 32'((j - 2) % 4));
        chk("rr_valid", 32'(o_valid), 32'd1);
      end
      step();
    end

    // Backpressure while streaming
    o_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_ready", 32'(i_ready), 32'd0);
      chk("bp_valid", 32'(o_valid), 32'd1);
      step();
    end
    o_ready = 1'b1;
    step(); step();
    i_valid = '0;
    step(); step(); step();

    // Sparse fairness: put ptr at 2, then channels 1 and 3 alternate starting at 3
    i_valid = 4'b0010;
    @(negedge clk);
    chk("fair_prime", 32'(i_ready), 32'b0010);
    step();
    i_valid = 4'b1010;
    @(negedge clk); chk("fair_0", 32'(i_ready), 32'b1000); step();
    @(negedge clk); chk("fair_1", 32'(i_ready), 32'b0010); step();
    @(negedge clk); chk("fair_2", 32'(i_ready), 32'b1000); step();
    i_valid = '0;
    step(); step(); step();

    round_lit("u_0020", 0, 16'h0020, 1'b0, 10'h001);
    round_lit("u_001f", 1, 16'h001F, 1'b0, 10'h000);
    round_lit("u_ffe0", 3, 16'hFFE0, 1'b0, 10'h3FF);
    round_lit("s_ffe0", 2, 16'hFFE0, 1'b1, 10'h3FF);
    round_lit("s_ffe1", 0, 16'hFFE1, 1'b1, 10'h000);
    round_lit("s_7fe0", 1, 16'h7FE0, 1'b1, 10'h1FF);
    round_lit("s_ffdf", 2, 16'hFFDF, 1'b1, 10'h3FF);
    i_signed = '0;

    // Reset with two samples in flight
    i_valid = 4'hF;
    step(); step(); step();
    reset = 1'b0;
    i_valid = '0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data",  32'(o_data),  32'd0);
    step();
    reset = 1'b1;
    i_valid = 4'b1100;
    @(negedge clk);
    chk("post_rst_grant", 32'(i_ready), 32'b0100);
    step();
    i_valid = '0;
    step();
    @(negedge clk);
    chk("post_rst_chan",  32'(o_chan),  32'd2);
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    step();

    // Mixed traffic with intermittent stalls, checked by the model
    for (int j = 0; j < 60; j++) begin
      i_valid  = 4'(j * 7 + 3);
      i_signed = 4'(j * 5);
      o_ready  = ((j % 5) != 2) && ((j % 7) != 4);
      for (int c = 0; c < N; c++) i_data[CW'(c)] = 16'(j * 4099 + c * 1031);
      step();
    end
    i_valid = '0;
    o_ready = 1'b1;
    for (int j = 0; j < P + 3; j++) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
